// File: rtl/m_seven_segment_scan_pkg.sv
// seg_pkg: shared constants and helpers for the seven-segment scan driver.
//   SEG_BLANK  - all segments and the decimal point dark (active-low pattern)
//   SEG_TABLE  - hex nibble -> active-low segment pattern, bit7 (dp) held at 1
//   hex_to_seg - table lookup for one nibble
package seg_pkg;

  typedef logic [7:0] seg_t;

  localparam seg_t SEG_BLANK = 8'hFF;

  // Entry k is the pattern for nibble k; bit order [7]=dp, [6:0]=g..a.
  localparam logic [15:0][7:0] SEG_TABLE = {
    8'h8E, 8'h86, 8'hA1, 8'hA7, 8'h83, 8'h88, 8'h98, 8'h80,
    8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
  };

  function automatic seg_t hex_to_seg(input logic [3:0] nib);
    return SEG_TABLE[nib];
  endfunction

endpackage

// File: rtl/m_seven_segment_scan_if.sv
// Interface bundling the data-load and display-pin signals of m_seven_segment_scan.
//   i_en     scan enable                 i_load  capture idat/idp/iblank
//   idat     4*N_DIGITS hex nibbles      idp     decimal point per digit
//   iblank   force digit dark            odat    segments, active-low
//   odig     digit selects               o_frame 1-cycle pulse at scan wrap
//   o_pend   pending buffer not yet displayed
// master: the driving register/counter logic; slave: the display driver.
interface m_seven_segment_scan_if #(
  parameter int N_DIGITS = 4
);
  logic                    i_en;
  logic                    i_load;
  logic [4*N_DIGITS-1:0]   idat;
  logic [N_DIGITS-1:0]     idp;
  logic [N_DIGITS-1:0]     iblank;
  logic [7:0]              odat;
  logic [N_DIGITS-1:0]     odig;
  logic                    o_frame;
  logic                    o_pend;

  modport master (
    output i_en, i_load, idat, idp, iblank,
    input  odat, odig, o_frame, o_pend
  );

  modport slave (
    input  i_en, i_load, idat, idp, iblank,
    output odat, odig, o_frame, o_pend
  );
endinterface

// File: rtl/m_seven_segment_scan_seg_decode.sv
// m_seg_decode: combinational nibble -> seven-segment pattern (active-low).
//   i_nib   hex nibble to show
//   i_dp    decimal point on (1) / off (0)
//   i_blank force the whole digit dark, dp included
//   o_seg   [7]=dp, [6:0]=g..a, active-low
module m_seg_decode
  import seg_pkg::*;
(
  input  logic [3:0] i_nib,
  input  logic       i_dp,
  input  logic       i_blank,
  output logic [7:0] o_seg
);

  seg_t w_hex;

  always_comb begin
    w_hex = hex_to_seg(i_nib);
    if (i_blank) begin
      o_seg = SEG_BLANK;
    end else begin
      o_seg = {~i_dp, w_hex[6:0]};
    end
  end

endmodule

// File: rtl/m_seven_segment_scan.sv
// m_seven_segment_scan: multiplexed N-digit hex seven-segment display driver.
// Scans one digit per REFRESH_DIV clocks, darkens every digit for the first
// DEAD_CYC clocks of each slot, and shows a double-buffered snapshot of the
// input data that only changes at a frame boundary (or while scanning is off).
// Ports:
//   clk     clock
//   rst_n   synchronous reset, active-low
//   io_bus  m_seven_segment_scan_if.slave (i_en, i_load, idat, idp, iblank in;
//           odat, odig, o_frame, o_pend out)
// Parameters: N_DIGITS (1..16), REFRESH_DIV (>=2), DEAD_CYC (0..REFRESH_DIV-1),
//             DIG_ACT_LOW (1: odig active-low, 0: active-high).
// Build option: define SEVSEG_LZB_EN for leading-zero blanking of the active buffer.
module m_seven_segment_scan
  import seg_pkg::*;
#(
  parameter int N_DIGITS    = 4,
  parameter int REFRESH_DIV = 50000,
  parameter int DEAD_CYC    = 16,
  parameter int DIG_ACT_LOW = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  m_seven_segment_scan_if.slave io_bus
);

  localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam int PRE_W = $clog2(REFRESH_DIV);
  localparam logic [PRE_W-1:0]    PRE_LAST = PRE_W'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0]    IDX_LAST = IDX_W'(N_DIGITS - 1);
  localparam logic [N_DIGITS-1:0] DIG_OFF  = {N_DIGITS{DIG_ACT_LOW != 0}};

  logic [PRE_W-1:0]        r_presc;
  logic [IDX_W-1:0]        r_idx;
  logic [4*N_DIGITS-1:0]   r_act_dat;
  logic [N_DIGITS-1:0]     r_act_dp;
  logic [N_DIGITS-1:0]     r_act_blank;
  logic [4*N_DIGITS-1:0]   r_pnd_dat;
  logic [N_DIGITS-1:0]     r_pnd_dp;
  logic [N_DIGITS-1:0]     r_pnd_blank;
  logic                    r_pend;
  logic                    r_frame;
  logic [7:0]              r_odat;
  logic [N_DIGITS-1:0]     r_odig;

  logic                    w_en;
  logic                    w_load;
  logic                    w_tick;
  logic                    w_wrap;
  logic                    w_dead;
  logic [3:0]              w_nib;
  logic                    w_dp;
  logic                    w_blk;
  logic [N_DIGITS-1:0]     w_sel;
  logic [N_DIGITS-1:0]     w_lzb;
  logic [7:0]              w_seg;

  assign w_en   = io_bus.i_en;
  assign w_load = io_bus.i_load;
  assign w_tick = (r_presc == PRE_LAST);
  // Frame boundary: last cycle of the last digit slot while scanning.
  assign w_wrap = w_en && w_tick && (r_idx == IDX_LAST);
  assign w_dead = (int'(r_presc) < DEAD_CYC);

`ifdef SEVSEG_LZB_EN
  // Walk from the most significant digit down; stop masking at the first
  // digit that has a nonzero nibble or a lit dp. Digit 0 is never masked.
  logic w_lead;
  always_comb begin
    w_lzb  = '0;
    w_lead = 1'b1;
    for (int unsigned j = 1; j < N_DIGITS; j++) begin
      if (w_lead && (r_act_dat[4*(N_DIGITS-j) +: 4] == 4'h0) && !r_act_dp[N_DIGITS-j]) begin
        w_lzb[N_DIGITS-j] = 1'b1;
      end else begin
        w_lead = 1'b0;
      end
    end
  end
`else
  assign w_lzb = '0;
`endif

  // Select the current digit's nibble, dp and blank state from the active buffer.
  always_comb begin
    w_nib = '0;
    w_dp  = 1'b0;
    w_blk = 1'b0;
    w_sel = '0;
    for (int unsigned k = 0; k < N_DIGITS; k++) begin
      if (r_idx == IDX_W'(k)) begin
        w_nib    = r_act_dat[4*k +: 4];
        w_dp     = r_act_dp[k];
        w_blk    = r_act_blank[k] | w_lzb[k];
        w_sel[k] = 1'b1;
      end
    end
  end

  m_seg_decode u_dec (
    .i_nib   (w_nib),
    .i_dp    (w_dp),
    .i_blank (w_blk | w_dead | !w_en),
    .o_seg   (w_seg)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_presc     <= '0;
      r_idx       <= '0;
      r_act_dat   <= '0;
      r_act_dp    <= '0;
      r_act_blank <= '0;
      r_pnd_dat   <= '0;
      r_pnd_dp    <= '0;
      r_pnd_blank <= '0;
      r_pend      <= 1'b0;
      r_frame     <= 1'b0;
      r_odat      <= SEG_BLANK;
      r_odig      <= DIG_OFF;
    end else begin
      r_frame <= w_wrap;

      if (!w_en) begin
        r_presc <= '0;
        r_idx   <= '0;
      end else if (w_tick) begin
        r_presc <= '0;
        r_idx   <= (r_idx == IDX_LAST) ? '0 : r_idx + 1'b1;
      end else begin
        r_presc <= r_presc + 1'b1;
      end

      // Buffer update. Off the boundary, a disabled scan drains pending into
      // active first; a same-cycle load then refills pending and the later
      // r_pend assignment keeps the flag set.
      if (w_wrap) begin
        if (w_load) begin
          r_act_dat   <= io_bus.idat;
          r_act_dp    <= io_bus.idp;
          r_act_blank <= io_bus.iblank;
        end else if (r_pend) begin
          r_act_dat   <= r_pnd_dat;
          r_act_dp    <= r_pnd_dp;
          r_act_blank <= r_pnd_blank;
        end
        r_pend <= 1'b0;
      end else begin
        if (!w_en && r_pend) begin
          r_act_dat   <= r_pnd_dat;
          r_act_dp    <= r_pnd_dp;
          r_act_blank <= r_pnd_blank;
          r_pend      <= 1'b0;
        end
        if (w_load) begin
          r_pnd_dat   <= io_bus.idat;
          r_pnd_dp    <= io_bus.idp;
          r_pnd_blank <= io_bus.iblank;
          r_pend      <= 1'b1;
        end
      end

      r_odat <= w_seg;
      if (!w_en || w_dead) begin
        r_odig <= DIG_OFF;
      end else begin
        r_odig <= DIG_OFF ^ w_sel;
      end
    end
  end

  assign io_bus.odat    = r_odat;
  assign io_bus.odig    = r_odig;
  assign io_bus.o_frame = r_frame;
  assign io_bus.o_pend  = r_pend;

endmodule
